// File: rtl/fighter_pkg.sv
// Shared types and defaults for the per-fighter pose sequencer.
package fighter_pkg;

   // Pose select to the sprite ROM / palette mux; encodings are fixed by the ROM layout.
   typedef enum logic [3:0] {
      STAND       = 4'd0,
      CROUCH      = 4'd1,
      JUMP        = 4'd2,
      KICK        = 4'd3,
      PUNCH       = 4'd4,
      BLOCK       = 4'd5,
      CROUCHPUNCH = 4'd6,
      DEAD        = 4'd7,
      STAND2      = 4'd8,
      MOVE        = 4'd9
   } pose_t;

   typedef enum logic [3:0] {
      StIdle,
      StMove,
      StCrouch,
      StJump,
      StPunch,
      StKick,
      StCpunch,
      StBlock,
      StDead
   } fsm_state_t;

   localparam int unsigned DefPunchFrames  = 12;
   localparam int unsigned DefKickFrames   = 16;
   localparam int unsigned DefCpunchFrames = 12;
   localparam int unsigned DefActiveStart  = 4;
   localparam int unsigned DefActiveEnd    = 7;
   localparam int unsigned DefJumpFrames   = 32;
   localparam int unsigned DefJumpStep     = 4;
   localparam int unsigned DefIdlePeriod   = 30;

   // Ground-level command decode; first match wins, both walk keys cancel out.
   function automatic fsm_state_t ground_eval(input logic jump, input logic kick,
                                              input logic punch, input logic block,
                                              input logic crouch, input logic move_l,
                                              input logic move_r);
      fsm_state_t res;
      if (jump)                 res = StJump;
      else if (kick)            res = StKick;
      else if (punch)           res = StPunch;
      else if (block)           res = StBlock;
      else if (crouch)          res = StCrouch;
      else if (move_l ^ move_r) res = StMove;
      else                      res = StIdle;
      return res;
   endfunction

   function automatic logic is_attack(input fsm_state_t s);
      return (s == StPunch) || (s == StKick) || (s == StCpunch);
   endfunction

endpackage

// File: rtl/fighter_pose_sequencer_if.sv
// Command/status bundle between game logic (master) and the pose sequencer (slave).
interface fighter_pose_sequencer_if;
   logic                frame_tick;
   logic                move_l;
   logic                move_r;
   logic                crouch;
   logic                jump;
   logic                punch;
   logic                kick;
   logic                block;
   logic                health_zero;
   logic                restart;
   fighter_pkg::pose_t  pose;
   logic [7:0]          jump_dy;
   logic                attack_active;
   logic                busy;

   modport master (
      output frame_tick, move_l, move_r, crouch, jump, punch, kick, block, health_zero, restart,
      input  pose, jump_dy, attack_active, busy
   );

   modport slave (
      input  frame_tick, move_l, move_r, crouch, jump, punch, kick, block, health_zero, restart,
      output pose, jump_dy, attack_active, busy
   );
endinterface

// File: rtl/jump_profile.sv
// Jump height generator: rises JUMP_STEP per tick for half the jump, then falls back to 0.
module jump_profile #(
   parameter int unsigned JUMP_FRAMES = 32,
   parameter int unsigned JUMP_STEP   = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_start,
   input  logic       i_step,
   input  logic       i_clear,
   output logic       o_done,
   output logic [7:0] o_dy
);
   localparam logic [7:0] Half = 8'(JUMP_FRAMES / 2);
   localparam logic [7:0] Last = 8'(JUMP_FRAMES - 1);
   localparam logic [7:0] Step = 8'(JUMP_STEP);

   logic [7:0] r_cnt;
   logic [7:0] r_dy;

   assign o_done = i_step && (r_cnt == Last);
   assign o_dy   = r_dy;

   // Height and frame count; start/clear both return to ground level.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n || i_clear || i_start) begin
         r_cnt <= '0;
         r_dy  <= '0;
      end else if (i_step) begin
         r_dy  <= (r_cnt < Half) ? (r_dy + Step) : (r_dy - Step);
         r_cnt <= o_done ? '0 : (r_cnt + 8'd1);
      end
   end
endmodule

// File: rtl/fighter_pose_sequencer.sv
// Per-fighter pose FSM: turns commands and KO status into a registered pose per frame.
module fighter_pose_sequencer
   import fighter_pkg::*;
#(
   parameter int unsigned PUNCH_FRAMES  = DefPunchFrames,
   parameter int unsigned KICK_FRAMES   = DefKickFrames,
   parameter int unsigned CPUNCH_FRAMES = DefCpunchFrames,
   parameter int unsigned ACTIVE_START  = DefActiveStart,
   parameter int unsigned ACTIVE_END    = DefActiveEnd,
   parameter int unsigned JUMP_FRAMES   = DefJumpFrames,
   parameter int unsigned JUMP_STEP     = DefJumpStep,
   parameter int unsigned IDLE_PERIOD   = DefIdlePeriod
) (
   input logic                     Clk,
   input logic                     Reset_n,
   fighter_pose_sequencer_if.slave bus
);
   localparam logic [7:0] PunchLast  = 8'(PUNCH_FRAMES - 1);
   localparam logic [7:0] KickLast   = 8'(KICK_FRAMES - 1);
   localparam logic [7:0] CpunchLast = 8'(CPUNCH_FRAMES - 1);
   localparam logic [7:0] ActStart   = 8'(ACTIVE_START);
   localparam logic [7:0] ActEnd     = 8'(ACTIVE_END);
   localparam logic [7:0] IdleLast   = 8'(IDLE_PERIOD - 1);

   fsm_state_t r_state;
   pose_t      r_pose;
   logic [7:0] r_cnt;
   logic [7:0] r_idle_cnt;
   logic       r_attack_active;
   logic       r_busy;

   fsm_state_t w_next;
   pose_t      w_pose_d;
   logic [7:0] w_cnt_d;
   logic [7:0] w_idle_cnt_d;
   logic       w_entering;
   logic       w_jump_done;
   logic [7:0] w_jump_dy;

   jump_profile #(
      .JUMP_FRAMES (JUMP_FRAMES),
      .JUMP_STEP   (JUMP_STEP)
   ) u_jump_profile (
      .i_clk   (Clk),
      .i_rst_n (Reset_n),
      .i_start ((w_next == StJump) && (r_state != StJump)),
      .i_step  ((r_state == StJump) && bus.frame_tick && !bus.health_zero),
      .i_clear (bus.health_zero),
      .o_done  (w_jump_done),
      .o_dy    (w_jump_dy)
   );

   // Next state: tick-gated transitions, with KO/restart acting on any cycle.
   always_comb begin
      w_next = r_state;
      case (r_state)
         StIdle, StMove, StBlock: begin
            if (bus.frame_tick) begin
               w_next = ground_eval(bus.jump, bus.kick, bus.punch, bus.block, bus.crouch,
                                    bus.move_l, bus.move_r);
            end
         end
         StCrouch: begin
            if (bus.frame_tick) begin
               if (bus.punch) w_next = StCpunch;
               else if (!bus.crouch) begin
                  w_next = ground_eval(bus.jump, bus.kick, bus.punch, bus.block, bus.crouch,
                                       bus.move_l, bus.move_r);
               end
            end
         end
         StPunch:  if (bus.frame_tick && (r_cnt == PunchLast)) w_next = StIdle;
         StKick:   if (bus.frame_tick && (r_cnt == KickLast)) w_next = StIdle;
         StCpunch: begin
            if (bus.frame_tick && (r_cnt == CpunchLast)) begin
               w_next = bus.crouch ? StCrouch : StIdle;
            end
         end
         StJump:   if (w_jump_done) w_next = StIdle;
         StDead:   if (bus.restart) w_next = StIdle;
         default:  w_next = StIdle;
      endcase
      if (bus.health_zero) w_next = StDead;
   end

   // Pose and counters for the next state; counters are zero outside their own state.
   always_comb begin
      w_entering   = (w_next != r_state);
      w_pose_d     = STAND;
      w_cnt_d      = '0;
      w_idle_cnt_d = '0;
      case (w_next)
         StIdle: begin
            if (!w_entering) begin
               w_pose_d     = r_pose;
               w_idle_cnt_d = r_idle_cnt;
               if (bus.frame_tick) begin
                  if (r_idle_cnt == IdleLast) begin
                     w_idle_cnt_d = '0;
                     w_pose_d     = (r_pose == STAND2) ? STAND : STAND2;
                  end else begin
                     w_idle_cnt_d = r_idle_cnt + 8'd1;
                  end
               end
            end
         end
         StMove:   w_pose_d = MOVE;
         StCrouch: w_pose_d = CROUCH;
         StJump:   w_pose_d = JUMP;
         StBlock:  w_pose_d = BLOCK;
         StDead:   w_pose_d = DEAD;
         StPunch, StKick, StCpunch: begin
            w_pose_d = (w_next == StPunch) ? PUNCH : (w_next == StKick) ? KICK : CROUCHPUNCH;
            if (!w_entering) w_cnt_d = bus.frame_tick ? (r_cnt + 8'd1) : r_cnt;
         end
         default:  w_pose_d = STAND;
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_state         <= StIdle;
         r_pose          <= STAND;
         r_cnt           <= '0;
         r_idle_cnt      <= '0;
         r_attack_active <= 1'b0;
         r_busy          <= 1'b0;
      end else begin
         r_state         <= w_next;
         r_pose          <= w_pose_d;
         r_cnt           <= w_cnt_d;
         r_idle_cnt      <= w_idle_cnt_d;
         r_attack_active <= is_attack(w_next) && (w_cnt_d >= ActStart) && (w_cnt_d <= ActEnd);
         r_busy          <= is_attack(w_next) || (w_next == StJump);
      end
   end

   assign bus.pose          = r_pose;
   assign bus.jump_dy       = w_jump_dy;
   assign bus.attack_active = r_attack_active;
   assign bus.busy          = r_busy;
endmodule

// File: tb/tb_fighter_pose_sequencer.sv
// Directed bench for fighter_pose_sequencer with hand-computed expectations.
module tb_fighter_pose_sequencer;
   import fighter_pkg::*;

   logic Clk;
   logic Reset_n;
   int   n_checks;
   int   n_fail;

   fighter_pose_sequencer_if bus ();

   fighter_pose_sequencer dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock cycle; frame_tick is high for this cycle only. Returns #1 after the edge.
   task automatic step(input logic t);
      @(negedge Clk);
      bus.frame_tick = t;
      @(posedge Clk);
      #1;
      bus.frame_tick = 1'b0;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) step(1'b1);
   endtask

   initial begin
      n_checks        = 0;
      n_fail          = 0;
      Reset_n         = 1'b0;
      bus.frame_tick  = 1'b0;
      bus.move_l      = 1'b0;
      bus.move_r      = 1'b0;
      bus.crouch      = 1'b0;
      bus.jump        = 1'b0;
      bus.punch       = 1'b0;
      bus.kick        = 1'b0;
      bus.block       = 1'b0;
      bus.health_zero = 1'b0;
      bus.restart     = 1'b0;

      // Reset state
      step(1'b0);
      step(1'b0);
      check_eq("rst_pose", 32'(bus.pose), 32'(STAND));
      check_eq("rst_dy", 32'(bus.jump_dy), 32'd0);
      check_eq("rst_busy", 32'(bus.busy), 32'd0);
      check_eq("rst_active", 32'(bus.attack_active), 32'd0);
      Reset_n = 1'b1;

      // Idle animation: STAND2 appears after the 30th tick
      ticks(29);
      check_eq("idle29_pose", 32'(bus.pose), 32'(STAND));
      check_eq("idle29_dy", 32'(bus.jump_dy), 32'd0);
      ticks(1);
      check_eq("idle30_pose", 32'(bus.pose), 32'(STAND2));
      ticks(5);
      check_eq("idle35_pose", 32'(bus.pose), 32'(STAND2));

      // Punch: 12 ticks, hitbox live for cnt 4..7, kick pulse ignored
      bus.punch = 1'b1;
      step(1'b1);
      bus.punch = 1'b0;
      check_eq("punch_pose", 32'(bus.pose), 32'(PUNCH));
      check_eq("punch_busy", 32'(bus.busy), 32'd1);
      check_eq("punch_act0", 32'(bus.attack_active), 32'd0);
      for (int k = 1; k <= 11; k++) begin
         bus.kick = (k == 2);
         step(1'b1);
         check_eq($sformatf("punch_act%0d", k), 32'(bus.attack_active),
                  32'((k >= 4) && (k <= 7)));
         check_eq($sformatf("punch_pose%0d", k), 32'(bus.pose), 32'(PUNCH));
      end
      bus.kick = 1'b0;
      step(1'b1);
      check_eq("punch_end_pose", 32'(bus.pose), 32'(STAND));
      check_eq("punch_end_busy", 32'(bus.busy), 32'd0);
      check_eq("punch_end_act", 32'(bus.attack_active), 32'd0);

      // Jump: up 4 px per tick to 64, then back down to 0 on tick 32
      bus.jump = 1'b1;
      step(1'b1);
      bus.jump = 1'b0;
      check_eq("jump_pose0", 32'(bus.pose), 32'(JUMP));
      check_eq("jump_dy0", 32'(bus.jump_dy), 32'd0);
      check_eq("jump_busy", 32'(bus.busy), 32'd1);
      for (int k = 1; k <= 31; k++) begin
         step(1'b1);
         check_eq($sformatf("jump_dy%0d", k), 32'(bus.jump_dy),
                  (k <= 16) ? 32'(4 * k) : 32'(4 * (32 - k)));
         if (k == 16 || k == 31) check_eq($sformatf("jump_pose%0d", k), 32'(bus.pose), 32'(JUMP));
      end
      step(1'b1);
      check_eq("jump_end_dy", 32'(bus.jump_dy), 32'd0);
      check_eq("jump_end_pose", 32'(bus.pose), 32'(STAND));
      check_eq("jump_end_busy", 32'(bus.busy), 32'd0);

      // Crouch -> crouch-punch -> crouch -> idle
      bus.crouch = 1'b1;
      step(1'b1);
      check_eq("crouch_pose", 32'(bus.pose), 32'(CROUCH));
      bus.punch = 1'b1;
      step(1'b1);
      bus.punch = 1'b0;
      check_eq("cp_pose", 32'(bus.pose), 32'(CROUCHPUNCH));
      check_eq("cp_busy", 32'(bus.busy), 32'd1);
      ticks(11);
      check_eq("cp11_pose", 32'(bus.pose), 32'(CROUCHPUNCH));
      step(1'b1);
      check_eq("cp_end_pose", 32'(bus.pose), 32'(CROUCH));
      check_eq("cp_end_busy", 32'(bus.busy), 32'd0);
      bus.crouch = 1'b0;
      step(1'b1);
      check_eq("uncrouch_pose", 32'(bus.pose), 32'(STAND));

      // KO mid-jump without a tick, restart gated by health_zero
      bus.jump = 1'b1;
      step(1'b1);
      bus.jump = 1'b0;
      ticks(10);
      check_eq("ko_pre_dy", 32'(bus.jump_dy), 32'd40);
      bus.health_zero = 1'b1;
      step(1'b0);
      check_eq("ko_pose", 32'(bus.pose), 32'(DEAD));
      check_eq("ko_dy", 32'(bus.jump_dy), 32'd0);
      check_eq("ko_busy", 32'(bus.busy), 32'd0);
      bus.restart = 1'b1;
      step(1'b0);
      check_eq("ko_hold_pose", 32'(bus.pose), 32'(DEAD));
      bus.health_zero = 1'b0;
      step(1'b0);
      bus.restart = 1'b0;
      check_eq("restart_pose", 32'(bus.pose), 32'(STAND));
      check_eq("restart_dy", 32'(bus.jump_dy), 32'd0);

      // KO mid-kick while the hitbox is live
      bus.kick = 1'b1;
      step(1'b1);
      bus.kick = 1'b0;
      check_eq("kick_pose", 32'(bus.pose), 32'(KICK));
      ticks(4);
      check_eq("kick_act4", 32'(bus.attack_active), 32'd1);
      bus.health_zero = 1'b1;
      step(1'b0);
      bus.health_zero = 1'b0;
      check_eq("kick_ko_pose", 32'(bus.pose), 32'(DEAD));
      check_eq("kick_ko_act", 32'(bus.attack_active), 32'd0);
      check_eq("kick_ko_busy", 32'(bus.busy), 32'd0);
      bus.restart = 1'b1;
      step(1'b0);
      bus.restart = 1'b0;
      check_eq("kick_restart_pose", 32'(bus.pose), 32'(STAND));

      // Walk decode and ground priority
      bus.move_l = 1'b1;
      bus.move_r = 1'b1;
      step(1'b1);
      check_eq("both_move_pose", 32'(bus.pose), 32'(STAND));
      bus.move_l = 1'b0;
      step(1'b1);
      check_eq("move_r_pose", 32'(bus.pose), 32'(MOVE));
      bus.move_r = 1'b0;
      step(1'b0);
      check_eq("move_notick_pose", 32'(bus.pose), 32'(MOVE));
      step(1'b1);
      check_eq("move_stop_pose", 32'(bus.pose), 32'(STAND));
      bus.jump  = 1'b1;
      bus.kick  = 1'b1;
      bus.block = 1'b1;
      step(1'b1);
      bus.jump  = 1'b0;
      bus.kick  = 1'b0;
      check_eq("prio_pose", 32'(bus.pose), 32'(JUMP));
      ticks(32);
      check_eq("prio_end_pose", 32'(bus.pose), 32'(STAND));
      step(1'b1);
      bus.block = 1'b0;
      check_eq("block_pose", 32'(bus.pose), 32'(BLOCK));
      check_eq("block_busy", 32'(bus.busy), 32'd0);

      // Reset mid-kick, no tick
      bus.kick = 1'b1;
      step(1'b1);
      bus.kick = 1'b0;
      ticks(5);
      check_eq("rst2_pre_act", 32'(bus.attack_active), 32'd1);
      Reset_n = 1'b0;
      step(1'b0);
      Reset_n = 1'b1;
      check_eq("rst2_pose", 32'(bus.pose), 32'(STAND));
      check_eq("rst2_act", 32'(bus.attack_active), 32'd0);
      check_eq("rst2_busy", 32'(bus.busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
